// File: rtl/sbox_builder.sv
// S-box generator: collects unique W-bit candidates from a chaotic word stream into
// a forward table and its inverse, with a deterministic fill phase if the source stalls.
module sbox_builder #(
  parameter int IN_W    = 23,
  parameter int W       = 8,
  parameter int SEL_LSB = 0,
  parameter int MAX_REJ = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  output logic            in_ready,
  input  logic [W-1:0]    rd_addr,
  input  logic            rd_inv,
  output logic [W-1:0]    rd_data,
  output logic            busy,
  output logic            done,
  output logic            fill_used,
  output logic [W:0]      count
);

  localparam int unsigned DEPTH = 1 << W;
  localparam int RW = $clog2(MAX_REJ + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COLLECT,
    S_FILL,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic         seen    [DEPTH];
  logic [W-1:0] fwd_mem [DEPTH];
  logic [W-1:0] inv_mem [DEPTH];

  logic [W-1:0] ptr, ptr_nxt;
  logic [W:0]   count_nxt;
  logic [RW-1:0] rej, rej_nxt;
  logic         fill_nxt;

  logic [W-1:0] cand;
  logic         wr_en;
  logic [W-1:0] wr_val;
  logic         seen_we;
  logic [W-1:0] seen_addr;
  logic         seen_d;
  logic         unused_in_bits;

  assign cand           = in_data[SEL_LSB +: W];
  assign unused_in_bits = ^in_data;

  assign in_ready = (state == S_COLLECT);
  assign busy     = (state == S_CLEAR) || (state == S_COLLECT) || (state == S_FILL);
  assign done     = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    count_nxt = count;
    rej_nxt   = rej;
    fill_nxt  = fill_used;
    wr_en     = 1'b0;
    wr_val    = cand;
    seen_we   = 1'b0;
    seen_addr = cand;
    seen_d    = 1'b1;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_CLEAR;
          ptr_nxt   = '0;
          count_nxt = '0;
          rej_nxt   = '0;
          fill_nxt  = 1'b0;
        end
      end

      S_CLEAR: begin
        seen_we   = 1'b1;
        seen_addr = ptr;
        seen_d    = 1'b0;
        ptr_nxt   = ptr + W'(1);
        if (ptr == '1) begin
          state_nxt = S_COLLECT;
          ptr_nxt   = '0;
        end
      end

      S_COLLECT: begin
        if (in_valid) begin
          if (!seen[cand]) begin
            wr_en     = 1'b1;
            seen_we   = 1'b1;
            count_nxt = count + (W+1)'(1);
            rej_nxt   = '0;
            if (count_nxt == (W+1)'(DEPTH)) state_nxt = S_DONE;
          end else if (rej != RW'(MAX_REJ)) begin
            rej_nxt = rej + RW'(1);
            // The entry into FILL resets the shared pointer so the scan starts at 0
            if (rej_nxt == RW'(MAX_REJ)) begin
              state_nxt = S_FILL;
              ptr_nxt   = '0;
              fill_nxt  = 1'b1;
            end
          end
        end
      end

      S_FILL: begin
        ptr_nxt = ptr + W'(1);
        if (!seen[ptr]) begin
          wr_en     = 1'b1;
          wr_val    = ptr;
          seen_we   = 1'b1;
          seen_addr = ptr;
          count_nxt = count + (W+1)'(1);
          if (count_nxt == (W+1)'(DEPTH)) state_nxt = S_DONE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      count     <= '0;
      rej       <= '0;
      fill_used <= 1'b0;
      rd_data   <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      count     <= count_nxt;
      rej       <= rej_nxt;
      fill_used <= fill_nxt;
      rd_data   <= rd_inv ? inv_mem[rd_addr] : fwd_mem[rd_addr];
    end
  end

  // Table RAMs carry no reset; stale seen bits are wiped by the CLEAR sweep
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        fwd_mem[count[W-1:0]] <= wr_val;
        inv_mem[wr_val]       <= count[W-1:0];
      end
      if (seen_we) seen[seen_addr] <= seen_d;
    end
  end

endmodule

// File: tb/tb_sbox_builder.sv
// Scoreboard bench for sbox_builder: a small (W=4, MAX_REJ=8) and a large (W=8, SEL_LSB=7)
// instance driven by randomized stimulus against a list-based reference model.
module tb_sbox_builder;

  localparam int K_RD = 0, K_CNT = 1, K_DONE = 2, K_BUSY = 3, K_RDY = 4, K_FILL = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_rst, s_start, s_valid, s_ri, s_ready, s_busy, s_done, s_fill;
  logic [22:0] s_data;
  logic [3:0]  s_ra, s_rd;
  logic [4:0]  s_cnt;
  logic        b_rst, b_start, b_valid, b_ri, b_ready, b_busy, b_done, b_fill;
  logic [22:0] b_data;
  logic [7:0]  b_ra, b_rd;
  logic [8:0]  b_cnt;

  sbox_builder #(.IN_W(23), .W(4), .SEL_LSB(0), .MAX_REJ(8)) u_small (
    .clk(clk), .rst(s_rst), .start(s_start), .in_valid(s_valid), .in_data(s_data),
    .in_ready(s_ready), .rd_addr(s_ra), .rd_inv(s_ri), .rd_data(s_rd), .busy(s_busy),
    .done(s_done), .fill_used(s_fill), .count(s_cnt));

  sbox_builder #(.IN_W(23), .W(8), .SEL_LSB(7), .MAX_REJ(1024)) u_big (
    .clk(clk), .rst(b_rst), .start(b_start), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready), .rd_addr(b_ra), .rd_inv(b_ri), .rd_data(b_rd), .busy(b_busy),
    .done(b_done), .fill_used(b_fill), .count(b_cnt));

  typedef struct {
    int    due;
    int    d;
    int    k;
    int    v;
    string nm;
  } chk_t;

  chk_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: list of accepted values in order, plus a seen set
  int  n_of  [2] = '{16, 256};
  int  mr_of [2] = '{8, 1024};
  int  m_fwd [2][256];
  bit  m_seen[2][256];
  int  m_cnt [2];
  int  m_rej [2];
  bit  m_col [2];
  bit  m_fill[2];
  logic [22:0] lfsr;

  function automatic logic [31:0] get_out(int d, int k);
    case (k)
      K_RD:    return d ? 32'(b_rd)    : 32'(s_rd);
      K_CNT:   return d ? 32'(b_cnt)   : 32'(s_cnt);
      K_DONE:  return d ? 32'(b_done)  : 32'(s_done);
      K_BUSY:  return d ? 32'(b_busy)  : 32'(s_busy);
      K_RDY:   return d ? 32'(b_ready) : 32'(s_ready);
      default: return d ? 32'(b_fill)  : 32'(s_fill);
    endcase
  endfunction

  initial begin : monitor
    int i;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      i = 0;
      while (i < q.size()) begin
        if (q[i].due <= cyc) begin
          a = get_out(q[i].d, q[i].k);
          tests++;
          if (q[i].due < cyc || a !== 32'(q[i].v)) begin
            fails++;
            $display("FAIL %s dut%0d cyc %0d: got %0d, expected %0d", q[i].nm, q[i].d, cyc, a, q[i].v);
          end
          q.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  task automatic push_exp(int d, int k, int v, int due, string nm);
    chk_t c;
    c.due = due; c.d = d; c.k = k; c.v = v; c.nm = nm;
    q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int d, bit st, bit vld, logic [22:0] data, int ra, bit ri);
    s_start = 1'b0; s_valid = 1'b0; s_data = '0; s_ra = '0; s_ri = 1'b0;
    b_start = 1'b0; b_valid = 1'b0; b_data = '0; b_ra = '0; b_ri = 1'b0;
    if (d == 0) begin
      s_start = st; s_valid = vld; s_data = data; s_ra = ra[3:0]; s_ri = ri;
    end else begin
      b_start = st; b_valid = vld; b_data = data; b_ra = ra[7:0]; b_ri = ri;
    end
  endtask

  task automatic idle(int d, int n);
    repeat (n) begin
      drive(d, 1'b0, 1'b0, '0, 0, 1'b0);
      tick();
    end
  endtask

  function automatic logic [22:0] mk_data(int d, int v);
    logic [31:0] r;
    r = $urandom;
    if (d == 0) return 23'((r & 32'h007F_FFF0) | 32'(v));
    return 23'((r & 32'h007F_807F) | (32'(v) << 7));
  endfunction

  function automatic int inv_of(int d, int a);
    for (int i = 0; i < m_cnt[d]; i++)
      if (m_fwd[d][i] == a) return i;
    return -1;
  endfunction

  task automatic do_reset(int d);
    int s;
    s = cyc;
    if (d == 0) s_rst = 1'b1; else b_rst = 1'b1;
    drive(d, 1'b0, 1'b0, '0, 0, 1'b0);
    push_exp(d, K_RDY, 0, s + 1, "rst_ready");
    push_exp(d, K_BUSY, 0, s + 1, "rst_busy");
    push_exp(d, K_DONE, 0, s + 1, "rst_done");
    push_exp(d, K_FILL, 0, s + 1, "rst_fill_used");
    push_exp(d, K_CNT, 0, s + 1, "rst_count");
    push_exp(d, K_RD, 0, s + 1, "rst_rd_data");
    m_col[d] = 1'b0;
    tick();
    if (d == 0) s_rst = 1'b0; else b_rst = 1'b0;
  endtask

  task automatic do_start(int d);
    int s, n;
    s = cyc;
    n = n_of[d];
    drive(d, 1'b1, 1'b0, '0, 0, 1'b0);
    m_cnt[d] = 0; m_rej[d] = 0; m_fill[d] = 1'b0;
    for (int i = 0; i < 256; i++) m_seen[d][i] = 1'b0;
    push_exp(d, K_BUSY, 1, s + 1, "start_busy");
    push_exp(d, K_DONE, 0, s + 1, "start_done");
    push_exp(d, K_CNT, 0, s + 1, "start_count");
    push_exp(d, K_FILL, 0, s + 1, "start_fill_used");
    push_exp(d, K_RDY, 0, s + n, "clear_ready_low");
    push_exp(d, K_RDY, 1, s + n + 1, "collect_ready");
    tick();
    idle(d, n);
    m_col[d] = 1'b1;
  endtask

  task automatic start_ignored(int d);
    int s;
    s = cyc;
    drive(d, 1'b1, 1'b0, '0, 0, 1'b0);
    push_exp(d, K_CNT, m_cnt[d], s + 1, "ign_start_count");
    push_exp(d, K_BUSY, 1, s + 1, "ign_start_busy");
    push_exp(d, K_RDY, 1, s + 1, "ign_start_ready");
    tick();
  endtask

  task automatic beat(int d, bit vld, logic [22:0] data);
    int s, v, n, last, fill_end;
    s = cyc;
    n = n_of[d];
    fill_end = -1;
    v = (d == 0) ? int'(data[3:0]) : int'(data[14:7]);
    drive(d, 1'b0, vld, data, 0, 1'b0);
    if (m_col[d] && vld) begin
      if (!m_seen[d][v]) begin
        m_fwd[d][m_cnt[d]] = v;
        m_cnt[d]++;
        m_seen[d][v] = 1'b1;
        m_rej[d] = 0;
        push_exp(d, K_CNT, m_cnt[d], s + 1, "accept_count");
        if (m_cnt[d] == n) begin
          m_col[d] = 1'b0;
          push_exp(d, K_DONE, 1, s + 1, "done_after_last");
          push_exp(d, K_RDY, 0, s + 1, "ready_low_at_done");
          push_exp(d, K_BUSY, 0, s + 1, "busy_low_at_done");
        end
      end else begin
        if (m_rej[d] < mr_of[d]) m_rej[d]++;
        push_exp(d, K_CNT, m_cnt[d], s + 1, "reject_count");
        if (m_rej[d] == mr_of[d]) begin
          m_col[d] = 1'b0;
          m_fill[d] = 1'b1;
          push_exp(d, K_FILL, 1, s + 1, "fill_entry_flag");
          push_exp(d, K_RDY, 0, s + 1, "fill_ready_low");
          push_exp(d, K_BUSY, 1, s + 1, "fill_busy");
          last = 0;
          for (int p = 0; p < n; p++) begin
            if (!m_seen[d][p]) begin
              m_fwd[d][m_cnt[d]] = p;
              m_cnt[d]++;
              m_seen[d][p] = 1'b1;
              push_exp(d, K_CNT, m_cnt[d], s + 2 + p, "fill_count");
              last = p;
            end
          end
          fill_end = s + 2 + last;
          push_exp(d, K_DONE, 1, fill_end, "done_after_fill");
        end
      end
    end
    tick();
    while (fill_end >= 0 && cyc < fill_end) idle(d, 1);
  endtask

  task automatic run_random(int d, int stop, int max_beats);
    int nb;
    bit vld;
    logic [22:0] data;
    nb = 0;
    while (m_col[d] && m_cnt[d] < stop && nb < max_beats) begin
      vld = ($urandom_range(0, 3) != 0);
      if (d == 1) begin
        if (vld) lfsr = {lfsr[21:0], lfsr[22] ^ lfsr[17]};
        data = lfsr;
      end else begin
        data = mk_data(0, int'($urandom_range(0, 15)));
      end
      beat(d, vld, data);
      nb++;
    end
    if (m_col[d] && m_cnt[d] < stop) begin
      tests++;
      fails++;
      $display("FAIL build_timeout dut%0d: got count %0d, expected %0d", d, m_cnt[d], stop);
    end
  endtask

  task automatic do_reads(int d);
    int s, n;
    n = n_of[d];
    s = cyc;
    push_exp(d, K_DONE, 1, s + 1, "done_held");
    push_exp(d, K_CNT, n, s + 1, "final_count");
    push_exp(d, K_FILL, int'(m_fill[d]), s + 1, "final_fill_used");
    for (int a = 0; a < n; a++) begin
      for (int ri = 0; ri < 2; ri++) begin
        s = cyc;
        drive(d, 1'b0, 1'b0, '0, a, ri[0]);
        if (ri == 0) push_exp(d, K_RD, m_fwd[d][a], s + 1, "read_fwd");
        else         push_exp(d, K_RD, inv_of(d, a), s + 1, "read_inv");
        tick();
      end
    end
  endtask

  initial begin
    int first_v, w;
    s_rst = 1'b1;
    b_rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, 0, 1'b0);
    lfsr = 23'($urandom) | 23'd1;
    tick();
    tick();
    s_rst = 1'b0;
    b_rst = 1'b0;
    do_reset(0);
    do_reset(1);

    // Ordered feed: identity tables, no fill
    do_start(0);
    for (int v = 0; v < 16; v++) beat(0, 1'b1, mk_data(0, v));
    do_reads(0);

    // Restart from DONE, back-to-back duplicate, ignored start, then random completion
    do_start(0);
    beat(0, 1'b1, mk_data(0, 3));
    beat(0, 1'b1, mk_data(0, 3));
    beat(0, 1'b1, mk_data(0, 5));
    start_ignored(0);
    run_random(0, 16, 4000);
    do_reads(0);

    // Stall on a constant value to force the fill phase
    do_start(0);
    for (int v = 0; v < 10; v++) beat(0, 1'b1, mk_data(0, v));
    for (int i = 0; i < 8; i++) beat(0, 1'b1, mk_data(0, 0));
    do_reads(0);

    // Large instance: reset mid-build at count 100, then full rebuild
    do_start(1);
    run_random(1, 100, 20000);
    first_v = m_fwd[1][0];
    do_reset(1);
    do_start(1);
    beat(1, 1'b1, mk_data(1, first_v));
    run_random(1, 256, 40000);
    do_reads(1);

    w = 0;
    while (q.size() != 0 && w < 20) begin
      idle(0, 1);
      w++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sbox_builder.md
# sbox_builder

Parametrised S-box generator for the chaotic image-encryption datapath. It consumes the stream of mixed chaotic words from the mixer stage and extracts a W-bit candidate from each word. Duplicate candidates are rejected using an internal seen bitmap. Accepted candidates build a forward table of 2^W entries and its inverse. If the chaotic source stalls on duplicates, a deterministic fill phase guarantees the build terminates. Both tables are then read by the substitution stage through one registered lookup port.

## Interface

Parameters:
- IN_W, 23: width of the incoming mixed chaotic word.
- W, 8: S-box element width; table depth is 2^W. Legal range 2..10.
- SEL_LSB, 0: bit offset of the extracted field; candidate = in_data[SEL_LSB+W-1:SEL_LSB]. Requires SEL_LSB+W <= IN_W.
- MAX_REJ, 1024: consecutive rejects that trigger the fill phase. Must be >= 1.

Ports:
- clk  in  1  system clock. One clock domain.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request to begin a build.
- in_valid  in  1  chaotic word valid.
- in_data  in  IN_W  mixed chaotic word.
- in_ready  out  1  high only in COLLECT.
- rd_addr  in  W  lookup address.
- rd_inv  in  1  selects the table: 0 = forward, 1 = inverse.
- rd_data  out  W  registered lookup result.
- busy  out  1  high in CLEAR, COLLECT and FILL.
- done  out  1  high in DONE; tables are complete and valid.
- fill_used  out  1  high when the fill phase ran during the last build.
- count  out  W+1  number of table entries written so far.

## Operation

- States: IDLE, CLEAR, COLLECT, FILL, DONE.
- IDLE / DONE:
  - start=1 moves to CLEAR.
  - On that transition, count, fill_used and the reject counter are zeroed.
- CLEAR:
  - Zeroes one seen bit per cycle, addresses 0..2^W-1.
  - Moves to COLLECT after the last address.
- COLLECT:
  - A beat is accepted when in_valid & in_ready.
  - Candidate v is taken from the SEL_LSB field.
  - If seen[v]=0 (new): fwd[count]=v, inv[v]=count, seen[v]=1, count+=1, reject counter cleared.
  - If seen[v]=1 (duplicate): no table write; reject counter +1, saturating at MAX_REJ.
  - Bits of in_data outside the selected field are ignored.
- Seen updates from one beat are visible to the very next beat. Back-to-back identical candidates: the first is accepted, the second is rejected.
- Exits from COLLECT:
  - count reaching 2^W goes to DONE; this check has priority.
  - Otherwise, the reject counter reaching MAX_REJ goes to FILL.
- FILL:
  - Scan pointer p starts at 0 and increments by 1 each cycle.
  - If seen[p]=0, p is written exactly as an accepted candidate would be.
  - in_ready=0 throughout; fill_used is set on entry.
  - Moves to DONE when count reaches 2^W.
- DONE: tables are held until the next start or reset.
- start while busy is ignored.
- Lookup: rd_data <= rd_inv ? inv[rd_addr] : fwd[rd_addr], in every state. Contents are guaranteed only while done=1.
- Invariant at DONE: fwd is a permutation of 0..2^W-1 and inv[fwd[i]]==i for all i.

## Timing

- Reset values: in_ready 0, busy 0, done 0, fill_used 0, count 0, rd_data 0; state IDLE.
- Table RAM contents are not reset. Stale seen bits are cleared by CLEAR.
- start in cycle t: busy=1 from t+1; CLEAR occupies t+1..t+2^W; in_ready=1 from t+2^W+1.
- An accept in cycle t updates count at t+1.
- The accept that makes count = 2^W gives done=1 and in_ready=0 in the next cycle.
- The reject that reaches MAX_REJ gives state FILL in the next cycle.
- FILL writes at most one entry per cycle and lasts at most 2^W cycles.
- rd_data latency is 1 cycle from rd_addr / rd_inv.
- rst=1 in any state returns to IDLE on the next edge with all outputs at their reset values. rst has priority over start.

## Test plan

- W=4, feed 0..15 once each: done one cycle after the 16th accept; fwd[i]=i, inv[i]=i, fill_used=0, count=16.
- W=4, feed 3,3,5 back-to-back with in_valid held: the second 3 is rejected; count goes 1,1,2; fwd[0]=3, fwd[1]=5, inv[5]=1.
- W=4, MAX_REJ=8: feed 0..9, then constant 0 → FILL after the 8th reject; fwd[10..15]=10..15; fill_used=1; done 16 FILL cycles after entry (p sweeps 0..15; the last missing value is 15).
- W=8, 23-bit LFSR stimulus, SEL_LSB=7: at done, fwd is a permutation and inv[fwd[i]]==i for all 256 i, read through rd_addr / rd_inv with 1-cycle latency.
- Assert rst at count=100 in COLLECT: next cycle all outputs are at reset values. A subsequent start rebuilds correctly, and values accepted before the reset are not treated as seen.
- start pulsed during COLLECT: ignored, count unaffected. start pulsed in DONE: CLEAR begins next cycle, done=0, count=0.
